// File: rtl/raster_scheduler.sv
// raster_scheduler: round-robin front end that serialises 144-bit triangle words onto the rasterizer D line.
// Optional WATCHDOG_EN macro adds a WAIT_DONE timeout that pulses timeout and returns to IDLE.
`default_nettype none

module raster_scheduler #(
    parameter int WORD_W      = 144,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 1048576
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              ras_d,
    input  logic              ras_done,
    output logic              busy,
    output logic              grant_id,
    output logic [CNT_W-1:0]  tri_cnt,
    output logic              timeout
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_BIT = 8'(WORD_W - 1);

    state_t              state;
    state_t              state_nxt;
    logic                rr_last;
    logic                grant;
    logic                xfer;
    logic [WORD_W-1:0]   word_sel;
    logic [WORD_W-2:0]   shreg;
    logic [7:0]          bit_cnt;
    logic                wdog_expire;

    // Tie goes to whoever was not served last; rr_last resets to 1 so requester 0 wins first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~rr_last;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && !grant && req0_valid;
    assign req1_ready = (state == IDLE) &&  grant && req1_valid;
    assign xfer       = req0_ready || req1_ready;
    assign word_sel   = grant ? req1_data : req0_data;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (xfer) state_nxt = SHIFT;
            SHIFT:     if (bit_cnt == 8'd0) state_nxt = WAIT_DONE;
            WAIT_DONE: if (ras_done || wdog_expire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // The MSB goes straight to ras_d at acceptance; the shift register only holds the remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg    <= '0;
            bit_cnt  <= 8'd0;
            ras_d    <= 1'b0;
            grant_id <= 1'b0;
            rr_last  <= 1'b1;
            tri_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ras_d <= 1'b0;
                    if (xfer) begin
                        shreg    <= word_sel[WORD_W-2:0];
                        ras_d    <= word_sel[WORD_W-1];
                        bit_cnt  <= LAST_BIT;
                        grant_id <= grant;
                        rr_last  <= grant;
                    end
                end
                SHIFT: begin
                    if (bit_cnt != 8'd0) begin
                        ras_d   <= shreg[WORD_W-2];
                        shreg   <= {shreg[WORD_W-3:0], 1'b0};
                        bit_cnt <= bit_cnt - 8'd1;
                    end else begin
                        ras_d <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    ras_d <= 1'b0;
                    if (ras_done) begin
                        tri_cnt <= tri_cnt + CNT_W'(1);
                    end
                end
                default: ras_d <= 1'b0;
            endcase
        end
    end

`ifdef WATCHDOG_EN
    logic [31:0] wdog_cnt;

    // Held at zero outside WAIT_DONE, so the first WAIT_DONE cycle sees a count of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= 32'd0;
        end else if (state != WAIT_DONE) begin
            wdog_cnt <= 32'd0;
        end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
        end
    end

    assign wdog_expire = (state == WAIT_DONE) && !ras_done &&
                         (wdog_cnt == 32'(WDOG_CYCLES - 1));
    assign timeout     = wdog_expire;
`else
    logic [31:0] unused_wdog;

    assign unused_wdog = 32'(WDOG_CYCLES);
    assign wdog_expire = 1'b0;
    assign timeout     = 1'b0;
`endif

endmodule

`default_nettype wire
